// File: rtl/mem_access_stage.sv
// Memory stage: drives the req/ack data port, stalls the front end while an
// access is outstanding, flags misalignment/timeout and registers MEM/WB.
module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_alu_out,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_mem_data,
    input  logic        in_mem_write,
    input  logic        in_mem_read,
    input  logic        in_mem_to_reg,
    input  logic        in_write_enable,
    output logic        out_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] out_wb_data,
    output logic [4:0]  out_rd,
    output logic        out_write_enable,
    output logic        out_misaligned,
    output logic        out_bus_error
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic        mem_op;
    logic        misaligned;
    logic        timeout;
    logic        rd_ok;

    logic [31:0] wb_data_nxt;
    logic [4:0]  rd_nxt;
    logic        we_nxt;
    logic        mis_nxt;
    logic        be_nxt;

    assign mem_op     = in_mem_read | in_mem_write;
    assign misaligned = mem_op && (in_alu_out[1:0] != 2'b00);
    assign timeout    = (state == ACCESS) && !dmem_ack
                     && (cnt == CW'(TIMEOUT - 1));
    assign rd_ok      = (in_rd != 5'd0);

    // Address and data come straight from the held EX/MEM register
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = in_mem_write;
    assign dmem_addr  = in_alu_out;
    assign dmem_wdata = in_mem_data;

    // Next-state, stall and MEM/WB capture values
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        out_stall   = 1'b0;
        wb_data_nxt = in_alu_out;
        rd_nxt      = in_rd;
        we_nxt      = 1'b0;
        mis_nxt     = 1'b0;
        be_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (misaligned) begin
                    mis_nxt = 1'b1;
                end else if (mem_op) begin
                    out_stall = 1'b1;
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end else begin
                    we_nxt = in_write_enable & rd_ok;
                end
            end
            ACCESS: begin
                out_stall = !dmem_ack && !timeout;
                if (dmem_ack) begin
                    wb_data_nxt = in_mem_to_reg ? dmem_rdata : in_alu_out;
                    we_nxt      = in_write_enable & rd_ok;
                    state_nxt   = IDLE;
                end else if (timeout) begin
                    be_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_wb_data      <= '0;
            out_rd           <= '0;
            out_write_enable <= 1'b0;
            out_misaligned   <= 1'b0;
            out_bus_error    <= 1'b0;
        end else begin
            out_wb_data      <= wb_data_nxt;
            out_rd           <= rd_nxt;
            out_write_enable <= we_nxt;
            out_misaligned   <= mis_nxt;
            out_bus_error    <= be_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT = 4).
// Inputs change 1ns after posedge; checks are made at posedge+1/+2.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_alu_out;
    logic [4:0]  in_rd;
    logic [31:0] in_mem_data;
    logic        in_mem_write;
    logic        in_mem_read;
    logic        in_mem_to_reg;
    logic        in_write_enable;
    logic        out_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_write_enable;
    logic        out_misaligned;
    logic        out_bus_error;

    int total = 0;
    int fails = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_alu_out(in_alu_out),
        .in_rd(in_rd),
        .in_mem_data(in_mem_data),
        .in_mem_write(in_mem_write),
        .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg),
        .in_write_enable(in_write_enable),
        .out_stall(out_stall),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .out_wb_data(out_wb_data),
        .out_rd(out_rd),
        .out_write_enable(out_write_enable),
        .out_misaligned(out_misaligned),
        .out_bus_error(out_bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        in_alu_out      = '0;
        in_rd           = '0;
        in_mem_data     = '0;
        in_mem_write    = 1'b0;
        in_mem_read     = 1'b0;
        in_mem_to_reg   = 1'b0;
        in_write_enable = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [4:0] rd);
        in_alu_out      = a;
        in_rd           = rd;
        in_mem_data     = '0;
        in_mem_write    = 1'b0;
        in_mem_read     = 1'b1;
        in_mem_to_reg   = 1'b1;
        in_write_enable = 1'b1;
    endtask

    initial begin
        nop();
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        tick();
        tick();
        chk("rst_wb", out_wb_data, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_we", out_write_enable, 0);
        chk("rst_mis", out_misaligned, 0);
        chk("rst_be", out_bus_error, 0);
        reset = 1'b0;
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", out_stall, 0);

        // ALU op
        tick();
        in_alu_out      = 32'h1234;
        in_rd           = 5'd5;
        in_write_enable = 1'b1;
        #1;
        chk("alu_stall", out_stall, 0);
        tick();
        chk("alu_wb", out_wb_data, 32'h1234);
        chk("alu_rd", out_rd, 5);
        chk("alu_we", out_write_enable, 1);

        // ALU op to x0 never writes
        in_rd = 5'd0;
        tick();
        chk("x0_we", out_write_enable, 0);
        nop();

        // Load, ack on 3rd ACCESS cycle
        load(32'h100, 5'd7);
        #1;
        chk("ld_idle_stall", out_stall, 1);
        chk("ld_idle_req", dmem_req, 0);
        tick();
        chk("ld_a1_req", dmem_req, 1);
        chk("ld_a1_stall", out_stall, 1);
        chk("ld_a1_bubble", out_write_enable, 0);
        chk("ld_a1_addr", dmem_addr, 32'h100);
        chk("ld_a1_we", dmem_we, 0);
        tick();
        chk("ld_a2_req", dmem_req, 1);
        chk("ld_a2_stall", out_stall, 1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_a3_req", dmem_req, 1);
        chk("ld_a3_stall", out_stall, 0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk("ld_wb", out_wb_data, 32'hDEADBEEF);
        chk("ld_rd", out_rd, 7);
        chk("ld_we", out_write_enable, 1);
        chk("ld_done_req", dmem_req, 0);

        // Store with 1-cycle ack, followed by ALU op
        in_alu_out   = 32'h200;
        in_mem_data  = 32'hCAFEF00D;
        in_mem_write = 1'b1;
        in_rd        = 5'd9;
        #1;
        chk("st_idle_stall", out_stall, 1);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("st_req", dmem_req, 1);
        chk("st_dwe", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h200);
        chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("st_stall", out_stall, 0);
        tick();
        dmem_ack = 1'b0;
        nop();
        in_alu_out      = 32'h55;
        in_rd           = 5'd3;
        in_write_enable = 1'b1;
        chk("st_we", out_write_enable, 0);
        #1;
        chk("st_next_stall", out_stall, 0);
        tick();
        nop();
        chk("st_next_wb", out_wb_data, 32'h55);
        chk("st_next_we", out_write_enable, 1);

        // Misaligned load
        load(32'h102, 5'd4);
        #1;
        chk("mis_stall", out_stall, 0);
        chk("mis_req", dmem_req, 0);
        tick();
        nop();
        chk("mis_flag", out_misaligned, 1);
        chk("mis_we", out_write_enable, 0);
        chk("mis_req2", dmem_req, 0);
        tick();
        chk("mis_clear", out_misaligned, 0);

        // Timeout, no ack
        load(32'h300, 5'd6);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", dmem_req, 1);
            chk("to_stall", out_stall, (i == 3) ? 0 : 1);
            chk("to_be_low", out_bus_error, 0);
            tick();
        end
        nop();
        #1;
        chk("to_be", out_bus_error, 1);
        chk("to_we", out_write_enable, 0);
        chk("to_req_off", dmem_req, 0);
        chk("to_stall_off", out_stall, 0);
        tick();
        chk("to_be_clear", out_bus_error, 0);

        // Ack on the 4th ACCESS cycle wins over timeout
        load(32'h304, 5'd6);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'h11223344;
                #1;
            end
            chk("ta_req", dmem_req, 1);
            chk("ta_stall", out_stall, (i == 3) ? 0 : 1);
            tick();
        end
        dmem_ack = 1'b0;
        nop();
        chk("ta_wb", out_wb_data, 32'h11223344);
        chk("ta_we", out_write_enable, 1);
        chk("ta_be", out_bus_error, 0);

        // Reset on the 2nd ACCESS cycle, late ack ignored
        load(32'h400, 5'd8);
        tick();
        tick();
        chk("ra_req", dmem_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF;
        chk("ra_req_off", dmem_req, 0);
        chk("ra_wb", out_wb_data, 0);
        chk("ra_rd", out_rd, 0);
        chk("ra_we", out_write_enable, 0);
        chk("ra_mis", out_misaligned, 0);
        chk("ra_be", out_bus_error, 0);
        #1;
        chk("ra_stall", out_stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("ra_late_we", out_write_enable, 0);
        chk("ra_late_wb", out_wb_data, 0);
        chk("ra_late_req", dmem_req, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
